// File: rtl/structures.sv
// Shared pipeline-register types and memory-access helpers for the 64-bit MIPS core.
package structures;

  typedef enum logic [2:0] {LD_NONE, LD_BYTE, LD_HALF, LD_WORD, LD_DWORD} mem_load_t;
  typedef enum logic [2:0] {ST_NONE, ST_BYTE, ST_HALF, ST_WORD, ST_DWORD} mem_store_t;
  typedef enum logic {IDLE, WAIT} mem_state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD} mem_size_t;

  typedef struct packed {
    logic [63:0] out;
    logic [63:0] B_data;
    mem_load_t   mem_load_type;
    mem_store_t  mem_store_type;
    logic        signed_mem_out;
    logic [4:0]  W_regnum;
    logic        write_enable;
    logic [63:0] pc4;
    logic        linkpc;
    logic        MFC0;
    logic        MTC0;
    logic [4:0]  cp0_rd;
    logic [2:0]  sel;
    logic        overflow;
    logic        break_;
    logic        syscall;
  } EX_regs_t;

  typedef struct packed {
    logic [63:0] out;
    logic [4:0]  W_regnum;
    logic        write_enable;
    logic [63:0] pc4;
    logic        linkpc;
    logic        MFC0;
    logic        MTC0;
    logic [4:0]  cp0_rd;
    logic [2:0]  sel;
    logic        overflow;
    logic        break_;
    logic        syscall;
    logic        bus_error;
    logic        addr_error;
  } MEM_regs_t;

  function automatic mem_size_t access_size(mem_load_t ld, mem_store_t st);
    mem_size_t sz;
    sz = SZ_DWORD;
    if (ld != LD_NONE) begin
      case (ld)
        LD_BYTE: sz = SZ_BYTE;
        LD_HALF: sz = SZ_HALF;
        LD_WORD: sz = SZ_WORD;
        default: sz = SZ_DWORD;
      endcase
    end else begin
      case (st)
        ST_BYTE: sz = SZ_BYTE;
        ST_HALF: sz = SZ_HALF;
        ST_WORD: sz = SZ_WORD;
        default: sz = SZ_DWORD;
      endcase
    end
    return sz;
  endfunction

  // Low address bits forced to the natural alignment of the access size.
  function automatic logic [2:0] align_offset(mem_size_t sz, logic [2:0] a);
    case (sz)
      SZ_BYTE: return a;
      SZ_HALF: return {a[2:1], 1'b0};
      SZ_WORD: return {a[2], 2'b00};
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic misaligned(mem_size_t sz, logic [2:0] a);
    return a != align_offset(sz, a);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data aligner: shifts the addressed lane down, truncates to the access
// width and sign- or zero-extends to 64 bits.
module mem_load_align
  import structures::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  offset,
  input  mem_size_t   size,
  input  logic        sign_ext,
  output logic [63:0] data
);

  logic [63:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    data    = shifted;
    case (size)
      SZ_BYTE: data = sign_ext ? {{56{shifted[7]}}, shifted[7:0]}   : {56'b0, shifted[7:0]};
      SZ_HALF: data = sign_ext ? {{48{shifted[15]}}, shifted[15:0]} : {48'b0, shifted[15:0]};
      SZ_WORD: data = sign_ext ? {{32{shifted[31]}}, shifted[31:0]} : {32'b0, shifted[31:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/core_mem.sv
// MEM stage: req/ack data-memory access with wait/timeout handling and load alignment.
// MEM_ALIGN_CHECK_EN: trap misaligned accesses as addr_error instead of force-aligning them.
module core_mem
  import structures::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  EX_regs_t    EX_regs,
  input  logic        flush,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        stall_mem,
  output logic [63:0] MEM_data,
  output MEM_regs_t   MEM_regs
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  mem_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             flushed, flushed_nxt;
  EX_regs_t         ex_hold, cur;
  MEM_regs_t        mem_nxt;

  logic        is_load, is_store, mem_op, addr_err, timeout, bubble;
  mem_size_t   size;
  logic [2:0]  a_eff;
  logic [63:0] load_data;

  // While waiting, the access is driven from a private copy so the bus stays stable.
  assign cur      = (state == WAIT) ? ex_hold : EX_regs;
  assign is_load  = cur.mem_load_type != LD_NONE;
  assign is_store = cur.mem_store_type != ST_NONE;
  assign mem_op   = is_load | is_store;
  assign size     = access_size(cur.mem_load_type, cur.mem_store_type);
  assign a_eff    = align_offset(size, cur.out[2:0]);

`ifdef MEM_ALIGN_CHECK_EN
  assign addr_err = mem_op & misaligned(size, cur.out[2:0]);
`else
  assign addr_err = 1'b0;
`endif

  assign dmem_we   = is_store;
  assign dmem_addr = {cur.out[63:3], 3'b000};

  always_comb begin
    dmem_be    = 8'hFF;
    dmem_wdata = cur.B_data;
    case (size)
      SZ_BYTE: begin
        dmem_be    = 8'h01 << a_eff;
        dmem_wdata = {8{cur.B_data[7:0]}};
      end
      SZ_HALF: begin
        dmem_be    = 8'h03 << a_eff;
        dmem_wdata = {4{cur.B_data[15:0]}};
      end
      SZ_WORD: begin
        dmem_be    = 8'h0F << a_eff;
        dmem_wdata = {2{cur.B_data[31:0]}};
      end
      default: ;
    endcase
  end

  mem_load_align u_align (
    .rdata    (dmem_rdata),
    .offset   (a_eff),
    .size     (size),
    .sign_ext (cur.signed_mem_out),
    .data     (load_data)
  );

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    flushed_nxt = flushed;
    dmem_req    = 1'b0;
    timeout     = 1'b0;
    bubble      = 1'b0;
    case (state)
      IDLE: begin
        dmem_req = mem_op & ~flush & ~addr_err & ~reset;
        bubble   = flush;
        if (dmem_req && !dmem_ack) begin
          state_nxt   = WAIT;
          cnt_nxt     = '0;
          flushed_nxt = 1'b0;
        end
      end
      WAIT: begin
        // A flush cannot abandon an issued access; it only marks the result as a bubble.
        bubble = flushed | flush;
        if (cnt == CNT_W'(TIMEOUT)) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          dmem_req    = ~reset;
          cnt_nxt     = cnt + CNT_W'(1);
          flushed_nxt = flushed | flush;
          if (dmem_ack) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stall_mem = dmem_req & ~dmem_ack;

  always_comb begin
    mem_nxt              = '0;
    mem_nxt.out          = (is_load && !timeout) ? load_data : cur.out;
    mem_nxt.W_regnum     = cur.W_regnum;
    mem_nxt.write_enable = cur.write_enable & ~timeout & ~addr_err;
    mem_nxt.pc4          = cur.pc4;
    mem_nxt.linkpc       = cur.linkpc;
    mem_nxt.MFC0         = cur.MFC0;
    mem_nxt.MTC0         = cur.MTC0;
    mem_nxt.cp0_rd       = cur.cp0_rd;
    mem_nxt.sel          = cur.sel;
    mem_nxt.overflow     = cur.overflow;
    mem_nxt.break_       = cur.break_;
    mem_nxt.syscall      = cur.syscall;
    mem_nxt.bus_error    = timeout;
    mem_nxt.addr_error   = addr_err;
    if (bubble || stall_mem) mem_nxt = '0;
  end

  // ---- state / MEM pipeline register boundary ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      flushed  <= 1'b0;
      MEM_regs <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      flushed  <= flushed_nxt;
      MEM_regs <= mem_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (state == IDLE) ex_hold <= EX_regs;
  end

  assign MEM_data = MEM_regs.out;

endmodule

// File: tb/tb_core_mem.sv
// Directed bench for core_mem: table of zero-wait accesses plus wait, timeout, flush and reset sequences.
module tb_core_mem;
  import structures::*;

  logic        clock = 1'b0;
  logic        reset;
  EX_regs_t    ex;
  logic        flush;
  logic        dmem_req, dmem_we, dmem_ack, stall_mem;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata, MEM_data;
  logic [7:0]  dmem_be;
  MEM_regs_t   MEM_regs;

  int errors = 0;
  int checks = 0;

  core_mem #(.TIMEOUT(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .EX_regs    (ex),
    .flush      (flush),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_be    (dmem_be),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .stall_mem  (stall_mem),
    .MEM_data   (MEM_data),
    .MEM_regs   (MEM_regs)
  );

  always #5 clock = ~clock;

  typedef struct {
    mem_load_t   ld;
    mem_store_t  st;
    logic        sgn;
    logic [63:0] addr;
    logic [63:0] bdata;
    logic [63:0] rdata;
    logic        wen;
    logic        exp_req;
    logic        exp_we;
    logic [7:0]  exp_be;
    logic [63:0] exp_wdata;
    logic [63:0] exp_out;
  } vec_t;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input mem_load_t ld, input mem_store_t st, input logic sgn,
                       input logic [63:0] out, input logic [63:0] bdata, input logic wen);
    ex                = '0;
    ex.mem_load_type  = ld;
    ex.mem_store_type = st;
    ex.signed_mem_out = sgn;
    ex.out            = out;
    ex.B_data         = bdata;
    ex.write_enable   = wen;
    ex.W_regnum       = 5'd9;
    ex.pc4            = 64'h400;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required $finish");
    $fatal(1);
  end

  initial begin
    vec_t v[11];
    v[0]  = '{LD_WORD,  ST_NONE,  1'b1, 64'h1004, 64'h0, 64'h80000001_00000000, 1'b1,
              1'b1, 1'b0, 8'hF0, 64'h0, 64'hFFFFFFFF_80000001};
    v[1]  = '{LD_NONE,  ST_BYTE,  1'b0, 64'h2003, 64'hAB, 64'h0, 1'b0,
              1'b1, 1'b1, 8'h08, 64'hABABABAB_ABABABAB, 64'h2003};
    v[2]  = '{LD_NONE,  ST_NONE,  1'b0, 64'h12345678, 64'h0, 64'h0, 1'b1,
              1'b0, 1'b0, 8'h00, 64'h0, 64'h12345678};
    v[3]  = '{LD_BYTE,  ST_NONE,  1'b0, 64'h3005, 64'h0, 64'h00009A00_00000000, 1'b1,
              1'b1, 1'b0, 8'h20, 64'h0, 64'h9A};
    v[4]  = '{LD_BYTE,  ST_NONE,  1'b1, 64'h3005, 64'h0, 64'h00009A00_00000000, 1'b1,
              1'b1, 1'b0, 8'h20, 64'h0, 64'hFFFFFFFF_FFFFFF9A};
    v[5]  = '{LD_NONE,  ST_HALF,  1'b0, 64'h4006, 64'h1234BEEF, 64'h0, 1'b0,
              1'b1, 1'b1, 8'hC0, 64'hBEEFBEEF_BEEFBEEF, 64'h4006};
    v[6]  = '{LD_NONE,  ST_WORD,  1'b0, 64'h5000, 64'hDEADBEEF_CAFEF00D, 64'h0, 1'b0,
              1'b1, 1'b1, 8'h0F, 64'hCAFEF00D_CAFEF00D, 64'h5000};
    v[7]  = '{LD_NONE,  ST_DWORD, 1'b0, 64'h6000, 64'h01234567_89ABCDEF, 64'h0, 1'b0,
              1'b1, 1'b1, 8'hFF, 64'h01234567_89ABCDEF, 64'h6000};
    v[8]  = '{LD_DWORD, ST_NONE,  1'b0, 64'h7008, 64'h0, 64'h88776655_44332211, 1'b1,
              1'b1, 1'b0, 8'hFF, 64'h0, 64'h88776655_44332211};
    v[9]  = '{LD_HALF,  ST_NONE,  1'b1, 64'h8002, 64'h0, 64'h00000000_80010000, 1'b1,
              1'b1, 1'b0, 8'h0C, 64'h0, 64'hFFFFFFFF_FFFF8001};
    v[10] = '{LD_WORD,  ST_NONE,  1'b0, 64'h9004, 64'h0, 64'h80000001_00000000, 1'b1,
              1'b1, 1'b0, 8'hF0, 64'h0, 64'h00000000_80000001};

    reset = 1'b1; flush = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    drive(LD_WORD, ST_NONE, 1'b0, 64'h1004, 64'h0, 1'b1);
    #2;
    check1("rst_req", dmem_req, 1'b0);
    check1("rst_stall", stall_mem, 1'b0);
    check64("rst_mem_data", MEM_data, 64'h0);
    check1("rst_mem_regs_zero", MEM_regs == '0, 1'b1);
    step();
    drive(LD_NONE, ST_NONE, 1'b0, 64'h0, 64'h0, 1'b0);
    reset = 1'b0;

    // zero-wait accesses from the table
    for (int i = 0; i < 11; i++) begin
      drive(v[i].ld, v[i].st, v[i].sgn, v[i].addr, v[i].bdata, v[i].wen);
      dmem_rdata = v[i].rdata;
      dmem_ack   = 1'b1;
      @(negedge clock);
      check1($sformatf("v%0d_req", i), dmem_req, v[i].exp_req);
      check1($sformatf("v%0d_stall", i), stall_mem, 1'b0);
      if (v[i].exp_req) begin
        check1($sformatf("v%0d_we", i), dmem_we, v[i].exp_we);
        check64($sformatf("v%0d_be", i), 64'(dmem_be), 64'(v[i].exp_be));
        check64($sformatf("v%0d_addr", i), dmem_addr, v[i].addr & ~64'h7);
        if (v[i].exp_we) check64($sformatf("v%0d_wdata", i), dmem_wdata, v[i].exp_wdata);
      end
      step();
      check64($sformatf("v%0d_out", i), MEM_regs.out, v[i].exp_out);
      check64($sformatf("v%0d_mem_data", i), MEM_data, v[i].exp_out);
      check1($sformatf("v%0d_wen", i), MEM_regs.write_enable, v[i].wen);
      check1($sformatf("v%0d_bus_err", i), MEM_regs.bus_error, 1'b0);
      check64($sformatf("v%0d_regnum", i), 64'(MEM_regs.W_regnum), 64'd9);
    end

    // ack after three wait cycles
    drive(LD_HALF, ST_NONE, 1'b0, 64'h6, 64'h0, 1'b1);
    dmem_rdata = 64'hFFFF0000_00000000;
    dmem_ack   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check1($sformatf("wait%0d_stall", k), stall_mem, 1'b1);
      check1($sformatf("wait%0d_req", k), dmem_req, 1'b1);
      check64($sformatf("wait%0d_addr", k), dmem_addr, 64'h0);
      step();
      check1($sformatf("wait%0d_bubble", k), MEM_regs == '0, 1'b1);
    end
    dmem_ack = 1'b1;
    @(negedge clock);
    check1("wait_ack_stall", stall_mem, 1'b0);
    step();
    check64("wait_out", MEM_regs.out, 64'hFFFF);
    check1("wait_wen", MEM_regs.write_enable, 1'b1);
    dmem_ack = 1'b0;

    // no ack: timeout after TIMEOUT+1 request cycles
    drive(LD_DWORD, ST_NONE, 1'b0, 64'hA000, 64'h0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check1($sformatf("to%0d_req", k), dmem_req, 1'b1);
      step();
    end
    @(negedge clock);
    check1("to_req_dropped", dmem_req, 1'b0);
    check1("to_stall_low", stall_mem, 1'b0);
    step();
    check1("to_bus_error", MEM_regs.bus_error, 1'b1);
    check1("to_wen", MEM_regs.write_enable, 1'b0);
    drive(LD_NONE, ST_NONE, 1'b0, 64'h77, 64'h0, 1'b1);
    dmem_ack = 1'b1;
    @(negedge clock);
    check1("late_ack_req", dmem_req, 1'b0);
    step();
    check64("late_ack_out", MEM_regs.out, 64'h77);
    check1("late_ack_bus_error", MEM_regs.bus_error, 1'b0);
    dmem_ack = 1'b0;

    // flush while waiting
    drive(LD_WORD, ST_NONE, 1'b0, 64'hB000, 64'h0, 1'b1);
    @(negedge clock);
    check1("fl_req0", dmem_req, 1'b1);
    step();
    flush = 1'b1;
    @(negedge clock);
    check1("fl_req_held", dmem_req, 1'b1);
    check1("fl_stall_held", stall_mem, 1'b1);
    step();
    flush = 1'b0;
    dmem_ack = 1'b1;
    dmem_rdata = 64'h12345678_9ABCDEF0;
    @(negedge clock);
    check1("fl_req_until_ack", dmem_req, 1'b1);
    check1("fl_stall_ack", stall_mem, 1'b0);
    step();
    check1("fl_result_zero", MEM_regs == '0, 1'b1);
    dmem_ack = 1'b0;
    drive(LD_NONE, ST_NONE, 1'b0, 64'h55, 64'h0, 1'b1);
    step();
    check64("fl_next_out", MEM_regs.out, 64'h55);
    check1("fl_next_wen", MEM_regs.write_enable, 1'b1);

    // flush in IDLE suppresses the request
    drive(LD_WORD, ST_NONE, 1'b0, 64'hB000, 64'h0, 1'b1);
    flush = 1'b1;
    dmem_ack = 1'b1;
    @(negedge clock);
    check1("fli_req", dmem_req, 1'b0);
    step();
    check1("fli_bubble", MEM_regs == '0, 1'b1);
    flush = 1'b0;

    // misaligned word load
    drive(LD_WORD, ST_NONE, 1'b0, 64'h1002, 64'h0, 1'b1);
    dmem_rdata = 64'h11223344_55667788;
    @(negedge clock);
`ifdef MEM_ALIGN_CHECK_EN
    check1("mis_req", dmem_req, 1'b0);
    check1("mis_stall", stall_mem, 1'b0);
    step();
    check1("mis_addr_error", MEM_regs.addr_error, 1'b1);
    check1("mis_wen", MEM_regs.write_enable, 1'b0);
`else
    check1("mis_req", dmem_req, 1'b1);
    check64("mis_addr", dmem_addr, 64'h1000);
    check64("mis_be", 64'(dmem_be), 64'h0F);
    step();
    check64("mis_out", MEM_regs.out, 64'h55667788);
    check1("mis_addr_error", MEM_regs.addr_error, 1'b0);
    check1("mis_wen", MEM_regs.write_enable, 1'b1);
`endif
    dmem_ack = 1'b0;

    // reset while waiting drops the request immediately
    drive(LD_BYTE, ST_NONE, 1'b0, 64'hC000, 64'h0, 1'b1);
    step();
    check1("rw_req_wait", dmem_req, 1'b1);
    reset = 1'b1;
    #1;
    check1("rw_req_dropped", dmem_req, 1'b0);
    check1("rw_stall", stall_mem, 1'b0);
    check64("rw_mem_data", MEM_data, 64'h0);
    drive(LD_NONE, ST_NONE, 1'b0, 64'h99, 64'h0, 1'b1);
    step();
    reset = 1'b0;
    @(negedge clock);
    check1("rw_after_stall", stall_mem, 1'b0);
    step();
    check64("rw_after_out", MEM_regs.out, 64'h99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
